axi4_lite_regfile: RTL
======================

Name: axi4_lite_regfile

Overview:
- Parametrised AXI4-Lite subordinate holding NUM_REGS memory-mapped registers of DATA_WIDTH bits.
- Binds to the subordinate modport of the axi4_lite interface through a thin wrapper. Ports below use the interface signal names.
- Exposes the register contents, per-register write pulses and hardware read-back inputs to the core, for example the ascon control/status block.
- Adds behaviour plain AXI plumbing lacks: independent AW/W acceptance, byte strobes, a read-only register mask, and error responses.

Parameters:
- ADDRESS_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width. Must be 32 or 64.
- NUM_REGS, 8, number of registers. Must be ≥2 and a power of 2.
- RO_MASK, 0, NUM_REGS-bit mask. Bit i set means register i is read-only and reads return hw_rdata.
- RESET_VALUE, 0, DATA_WIDTH-bit reset value of every writable register.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awaddr  in  ADDRESS_WIDTH  write address
- awvalid/awready  in/out  1  write-address handshake
- awprot  in  3  ignored
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte-lane enables
- wvalid/wready  in/out  1  write-data handshake
- bresp  out  2  write response
- bvalid/bready  out/in  1  write-response handshake
- araddr  in  ADDRESS_WIDTH  read address
- arvalid/arready  in/out  1  read-address handshake
- arprot  in  3  ignored
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid/rready  out/in  1  read handshake
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i at slice i
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on committed write
- hw_rdata  in  NUM_REGS*DATA_WIDTH  read-back values for read-only registers

Behaviour:
- Clock and reset: single clock aclk. aresetn is asynchronous, active-low.
- Reset state:
  - All valid and ready outputs are 0.
  - bresp, rresp and rdata are 0.
  - wr_pulse is 0.
  - Writable registers load RESET_VALUE.
  - awready, wready and arready are registered. They rise on the first aclk edge after aresetn deasserts.
- Address decode:
  - LSB = log2(DATA_WIDTH/8).
  - index = addr[LSB +: log2(NUM_REGS)].
  - Out of range when addr ≥ NUM_REGS*(DATA_WIDTH/8). Response DECERR (2'b11).
  - Low LSB address bits are ignored.
- Write path, state per channel EMPTY/HELD:
  - awready = AW slot empty and no pending B. AW is captured on its handshake, and awready drops next cycle.
  - wready follows the same rule for the W slot.
  - AW and W may arrive in any order or on the same edge.
  - Commit happens on the edge where both slots are HELD:
    - In range and writable: apply wdata only on byte lanes with wstrb=1. Set wr_pulse[index] for exactly one cycle. bresp=OKAY.
    - Read-only register: no update, no pulse, bresp=SLVERR (2'b10).
    - Out of range: no update, no pulse, bresp=DECERR.
  - bvalid rises on the commit edge and is held with a stable bresp until bready. Both slots then clear, and readies rise the following cycle.
  - Write throughput is at most one write per 3 cycles. Acceptable.
- Read path, states IDLE/RESP:
  - arready = 1 in IDLE. On the AR handshake, rdata/rresp are registered and rvalid=1 on the same edge.
  - rdata source: reg_q[index] for a writable register, or hw_rdata[index] for a read-only one (OKAY). Out of range gives rdata 0 with DECERR.
  - rvalid, rdata and rresp are held until rready. Return to IDLE, with arready back to 1 the next cycle.
- Read and write channels are fully independent. If a read of register i is sampled on the same edge a write to i commits, the read returns the pre-write value.
- Reset mid-transaction: all held state is discarded. No partial write ever reaches the registers.

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Read FSM state enum and write-slot state enum.
  - A strobe-merge function (old, new, strb) returning DATA_WIDTH bits.
- One sub-module is natural: axi4_lite_wr_capture, the AW/W capture-and-join logic emitting a single commit strobe with address, data and strobe.

Test Plan:
- Reset with NUM_REGS=8, RESET_VALUE=0xA5A5A5A5: read 0x08 → rdata 0xA5A5A5A5, OKAY. After release, readies are 1 within 1 cycle.
- AW 0x08 presented 3 cycles before W 0xDEADBEEF/strb 0xF: bresp OKAY one cycle after the W handshake, reg_q[2]=0xDEADBEEF, wr_pulse=8'b0000_0100 for one cycle.
- Then write 0x11223344 with strb 0b0101 to 0x08: reg_q[2]=0xDE22BE44.
- RO_MASK=8'h80, hw_rdata[7]=0x12345678:
  - Write 0x1C → SLVERR, no wr_pulse.
  - Read 0x1C → 0x12345678, OKAY.
- Read/write 0x40 (out of range) → DECERR, rdata 0, no register change.
- Hold bready and rready low for 10 cycles: bvalid/rvalid and their payloads stay stable, awready/wready/arready stay 0. Then assert aresetn=0 mid-hold: all valids drop asynchronously and registers return to RESET_VALUE.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Brief    : Shared AXI4-Lite response codes, FSM state types, strobe merge.
// Revision : 1.0
// ============================================================================
package axi4_lite_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_state_t;

  // Operates at the widest supported bus; callers cast to their own width.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_val,
    input logic [MAX_DATA_WIDTH-1:0] new_val,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      merged[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Brief    : AXI4-Lite bus bundle with manager (master) and subordinate views.
// Revision : 1.0
// ============================================================================
interface axi4_lite_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [2:0]                awprot;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic                      arvalid;
  logic                      arready;
  logic [2:0]                arprot;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_wr_capture.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_wr_capture
// Brief    : Independent AW/W slot capture joined into a single commit strobe.
// Revision : 1.0
// ============================================================================
module axi4_lite_wr_capture
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic                     bvalid,
  input  logic                     bready,
  output logic                     commit,
  output logic [ADDRESS_WIDTH-1:0] commit_addr,
  output logic [DATA_WIDTH-1:0]    commit_data,
  output logic [DATA_WIDTH/8-1:0]  commit_strb
);

  slot_state_t aw_state, aw_next;
  slot_state_t w_state,  w_next;
  logic        release_slots;
  logic        bvalid_next;

  // Slots stay HELD while the response is outstanding so the join fires once.
  assign commit        = (aw_state == SLOT_HELD) && (w_state == SLOT_HELD) && !bvalid;
  assign release_slots = bvalid && bready;
  assign bvalid_next   = commit || (bvalid && !bready);

  always_comb begin
    aw_next = aw_state;
    w_next  = w_state;
    if (release_slots) begin
      aw_next = SLOT_EMPTY;
      w_next  = SLOT_EMPTY;
    end else begin
      if (aw_state == SLOT_EMPTY && awvalid && awready) aw_next = SLOT_HELD;
      if (w_state == SLOT_EMPTY && wvalid && wready)    w_next  = SLOT_HELD;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_state    <= SLOT_EMPTY;
      w_state     <= SLOT_EMPTY;
      awready     <= 1'b0;
      wready      <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
      commit_strb <= '0;
    end else begin
      aw_state <= aw_next;
      w_state  <= w_next;
      awready  <= (aw_next == SLOT_EMPTY) && !bvalid_next;
      wready   <= (w_next == SLOT_EMPTY) && !bvalid_next;
      if (aw_state == SLOT_EMPTY && awvalid && awready) commit_addr <= awaddr;
      if (w_state == SLOT_EMPTY && wvalid && wready) begin
        commit_data <= wdata;
        commit_strb <= wstrb;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_regfile
// Brief    : AXI4-Lite register file with byte strobes, read-only mask, errors.
// Revision : 1.0
// ============================================================================
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                           ADDRESS_WIDTH = 32,
  parameter int                           DATA_WIDTH    = 32,
  parameter int                           NUM_REGS      = 8,
  parameter logic [NUM_REGS-1:0]          RO_MASK       = '0,
  parameter logic [DATA_WIDTH-1:0]        RESET_VALUE   = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi4_lite_if.slave                     axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
  logic                     commit;
  logic [ADDRESS_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0]    commit_data;
  logic [STRB_WIDTH-1:0]    commit_strb;

  axi4_lite_wr_capture #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_wr_capture (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .awaddr      (axi.awaddr),
    .awvalid     (axi.awvalid),
    .awready     (axi.awready),
    .wdata       (axi.wdata),
    .wstrb       (axi.wstrb),
    .wvalid      (axi.wvalid),
    .wready      (axi.wready),
    .bvalid      (axi.bvalid),
    .bready      (axi.bready),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_idx      = commit_addr[LSB +: IDX_W];
  assign w_in_range = (commit_addr[ADDRESS_WIDTH-1:LSB+IDX_W] == '0);
  assign w_en       = commit && w_in_range && !RO_MASK[w_idx];
  assign w_merged   = DATA_WIDTH'(strb_merge(MAX_DATA_WIDTH'(regs[w_idx]),
                                             MAX_DATA_WIDTH'(commit_data),
                                             MAX_STRB_WIDTH'(commit_strb)));

  // Read-only slots hold zero; their readable value comes from hw_rdata.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RO_MASK[i] ? '0 : RESET_VALUE;
      end
    end else if (w_en) begin
      regs[w_idx] <= w_merged;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axi.bvalid <= 1'b0;
      axi.bresp  <= OKAY;
      wr_pulse   <= '0;
    end else begin
      axi.bvalid <= commit || (axi.bvalid && !axi.bready);
      wr_pulse   <= w_en ? (NUM_REGS'(1) << w_idx) : '0;
      if (commit) begin
        if (!w_in_range)          axi.bresp <= DECERR;
        else if (RO_MASK[w_idx])  axi.bresp <= SLVERR;
        else                      axi.bresp <= OKAY;
      end
    end
  end

  rd_state_t             rd_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_in_range;
  logic [DATA_WIDTH-1:0] r_data;
  resp_t                 r_resp;

  always_comb begin
    r_idx      = axi.araddr[LSB +: IDX_W];
    r_in_range = (axi.araddr[ADDRESS_WIDTH-1:LSB+IDX_W] == '0);
    r_data     = '0;
    r_resp     = DECERR;
    if (r_in_range) begin
      r_resp = OKAY;
      r_data = RO_MASK[r_idx] ? hw_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH] : regs[r_idx];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state    <= RD_IDLE;
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (axi.arvalid && axi.arready) begin
            rd_state    <= RD_RESP;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b1;
            axi.rdata   <= r_data;
            axi.rresp   <= r_resp;
          end else begin
            axi.arready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (axi.rready) begin
            rd_state    <= RD_IDLE;
            axi.arready <= 1'b1;
            axi.rvalid  <= 1'b0;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{axi.awprot, axi.arprot, axi.araddr[LSB-1:0], commit_addr[LSB-1:0]};

endmodule
`default_nettype wire
